eth_recv: RTL
=============

ETH_RECV -- requirements
Module: eth_recv

Interface
REQ-001 Parameter ip_daddr, default {8'd10,8'd0,8'd0,8'd1}, local IPv4 address accepted as destination.
REQ-002 Parameter udp_sport, default 16'd53, required UDP source port.
REQ-003 Parameter dport_min, default 16'd50001, lowest accepted UDP destination port.
REQ-004 Parameter dport_max, default 16'd51000, highest accepted UDP destination port.
REQ-005 clk156  input  1  sole clock; all logic on its rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 m_axis_rx_tvalid  input  1  MAC RX beat valid; no backpressure, so there is no tready.
REQ-008 m_axis_rx_tdata  input  64  beat data; byte lane 0 (tdata[7:0]) is the first byte on the wire.
REQ-009 m_axis_rx_tkeep  input  8  byte enables; ignored except on the last beat.
REQ-010 m_axis_rx_tlast  input  1  last beat of frame.
REQ-011 m_axis_rx_tuser  input  1  on the tlast beat: 1 = good frame, 0 = MAC-flagged bad frame.
REQ-012 hdr_valid  output  1  one-cycle pulse marking a qualified DNS response.
REQ-013 hdr_saddr  output  32  IP source address of the last qualified frame.
REQ-014 hdr_dport  output  16  UDP destination port of the last qualified frame.
REQ-015 hdr_dns_id  output  16  DNS ID of the last qualified frame.
REQ-016 rx_frame_cnt / rx_dns_cnt / rx_err_cnt  output  32 each  counters for total frames, qualified frames and error frames.

Function
REQ-017 The block SHALL run a state machine with three states.
- IDLE: a tvalid beat is header beat 0; go to HDR, or end the frame at once if tlast.
- HDR: capture beats 0-5 (bytes 0-47); after beat 5 go to PAYLOAD.
- PAYLOAD: discard beats until tlast, then go to IDLE.
REQ-018 A cycle with tvalid=0 in any state SHALL hold the state, beat index and accumulators unchanged.
REQ-019 Fields are big-endian (first byte = MSB) and SHALL be extracted at these byte offsets.
- ethertype 12-13; ver/ihl 14; proto 23; IP checksum 24-25.
- saddr 26-29; daddr 30-33; sport 34-35; dport 36-37.
- DNS id 42-43; QR = bit 7 of byte 44.
REQ-020 The IP checksum check SHALL work as follows.
- Sum the ten 16-bit words at bytes 14-33, checksum field included, into an accumulator of at least 20 bits.
- Fold the carries back in twice.
- The check passes if and only if the result is 16'hFFFF.
REQ-021 A frame SHALL qualify only if all of the following hold.
- ethertype = 16'h0800, byte 14 = 8'h45, proto = 8'd17, daddr = ip_daddr.
- sport = udp_sport, and dport_min <= dport <= dport_max (inclusive).
- QR = 1, checksum passes, and tuser = 1 on the tlast beat.
REQ-022 A frame whose tlast arrives before header beat 5 is a runt; a runt SHALL NOT qualify and SHALL count as an error.
REQ-023 The cycle after each tlast beat, the block SHALL do the following.
- rx_frame_cnt += 1.
- If the frame qualified: rx_dns_cnt += 1, hdr_valid = 1, and update hdr_saddr, hdr_dport, hdr_dns_id.
- If the frame is a runt, had tuser = 0, or failed the checksum: rx_err_cnt += 1.
REQ-024 A frame that is well-formed but fails only the address, port, protocol or QR filters SHALL increment rx_frame_cnt only.
REQ-025 The hdr_* outputs SHALL hold their values between pulses; hdr_valid SHALL be 0 in every other cycle.
REQ-026 All three counters SHALL wrap from 32'hFFFFFFFF to 0.
REQ-027 Latency from the tlast beat to hdr_valid SHALL be exactly 1 cycle.
REQ-028 Back-to-back frames (a new beat 0 in the cycle right after tlast) SHALL be accepted with no lost beats.

Reset
REQ-029 While sys_rst_n = 0, the state SHALL be IDLE and hdr_valid, hdr_saddr, hdr_dport, hdr_dns_id and all counters SHALL be 0.
REQ-030 If reset is asserted mid-frame, the frame is abandoned; after release, the next tvalid beat SHALL be treated as beat 0 of a new frame.

Configuration
REQ-031 With macro ETH_RECV_CSUM_EN defined, the checksum check of REQ-020 SHALL be compiled in.
REQ-032 Without ETH_RECV_CSUM_EN, the checksum logic SHALL be absent, every frame SHALL pass the checksum term, and a bad checksum SHALL never cause an error count.

Verification
REQ-033 Good frame: 1020-byte frame, 128 beats, last tkeep 8'h0F, saddr 10.0.1.1, dport 50001, QR=1, valid checksum, tuser=1 -> one cycle after tlast: hdr_valid=1, hdr_saddr=32'h0A000101, hdr_dport=50001; frame=1, dns=1, err=0.
REQ-034 Checksum error: same frame with byte 24 inverted -> with ETH_RECV_CSUM_EN: err=1, dns=0, no pulse; without the macro: pulse and dns=1.
REQ-035 Port out of range: dport 51001, then dport 51000 -> first frame: frame_cnt=1, no pulse; second frame: pulse, hdr_dport=51000.
REQ-036 Runt and bad frame: 3-beat frame, then a good frame with tuser=0 -> err=2, dns=0, frame=2, no pulses.
REQ-037 Reset mid-frame: sys_rst_n low for 2 cycles at beat 3, remaining beats continue, then one good frame -> counters read 0 during reset; at the end frame=2, dns=1, err=0.
REQ-038 Back-to-back: 3 good frames with zero gap, dports 50001/50002/50003 -> three pulses, 128 cycles apart, with matching hdr_dport; dns=3.

Source files
------------

// File: rtl/eth_recv.sv
// UDP/IPv4 DNS-response header receiver on a 64-bit AXI-Stream MAC RX port.
// Define ETH_RECV_CSUM_EN to compile in the IPv4 header checksum check.
module eth_recv #(
  parameter logic [31:0] ip_daddr  = {8'd10, 8'd0, 8'd0, 8'd1},
  parameter logic [15:0] udp_sport = 16'd53,
  parameter logic [15:0] dport_min = 16'd50001,
  parameter logic [15:0] dport_max = 16'd51000
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic        m_axis_rx_tvalid,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tuser,
  output logic        hdr_valid,
  output logic [31:0] hdr_saddr,
  output logic [15:0] hdr_dport,
  output logic [15:0] hdr_dns_id,
  output logic [31:0] rx_frame_cnt,
  output logic [31:0] rx_dns_cnt,
  output logic [31:0] rx_err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2} state_t;

  // Big-endian 16-bit word starting at byte lane 'lane' of a beat.
  function automatic logic [15:0] be16(input logic [63:0] d, input logic [2:0] lane);
    return {d[{lane, 3'b000} +: 8], d[{lane + 3'd1, 3'b000} +: 8]};
  endfunction

  state_t      state, nxt_state;
  logic [2:0]  beat_idx, nxt_beat, cur_beat;
  logic [15:0] ethertype, nxt_ethertype, sport, nxt_sport, dport, nxt_dport;
  logic [15:0] dns_id, nxt_dns_id;
  logic [7:0]  ver_ihl, nxt_ver_ihl, proto, nxt_proto;
  logic [31:0] saddr, nxt_saddr, daddr, nxt_daddr;
  logic        qr, nxt_qr;
  logic        capture, frame_end, runt, hdr_match, csum_ok, qualify, frame_err;
  logic        unused_tkeep;

  // Frame length is never needed, so byte enables carry no information here.
  assign unused_tkeep = ^m_axis_rx_tkeep;

  assign capture   = m_axis_rx_tvalid && (state != PAYLOAD);
  assign cur_beat  = (state == IDLE) ? 3'd0 : beat_idx;
  assign frame_end = m_axis_rx_tvalid && m_axis_rx_tlast;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      beat_idx <= 3'd0;
    end else begin
      state    <= nxt_state;
      beat_idx <= nxt_beat;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_beat  = beat_idx;
    if (m_axis_rx_tvalid) begin
      case (state)
        IDLE: begin
          if (m_axis_rx_tlast) begin
            nxt_state = IDLE;
          end else begin
            nxt_state = HDR;
            nxt_beat  = 3'd1;
          end
        end
        HDR: begin
          if (m_axis_rx_tlast) begin
            nxt_state = IDLE;
            nxt_beat  = 3'd0;
          end else if (beat_idx == 3'd5) begin
            nxt_state = PAYLOAD;
            nxt_beat  = 3'd0;
          end else begin
            nxt_beat  = beat_idx + 3'd1;
          end
        end
        PAYLOAD: begin
          if (m_axis_rx_tlast) begin
            nxt_state = IDLE;
          end else begin
            nxt_state = PAYLOAD;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_beat  = 3'd0;
        end
      endcase
    end else begin
      nxt_state = state;
    end
  end

  // Next field values merge the current beat so a tlast on beat 5 still qualifies.
  always_comb begin
    nxt_ethertype = ethertype;
    nxt_ver_ihl   = ver_ihl;
    nxt_proto     = proto;
    nxt_saddr     = saddr;
    nxt_daddr     = daddr;
    nxt_sport     = sport;
    nxt_dport     = dport;
    nxt_dns_id    = dns_id;
    nxt_qr        = qr;
    if (capture) begin
      case (cur_beat)
        3'd1: begin
          nxt_ethertype = be16(m_axis_rx_tdata, 3'd4);
          nxt_ver_ihl   = m_axis_rx_tdata[55:48];
        end
        3'd2: nxt_proto = m_axis_rx_tdata[63:56];
        3'd3: begin
          nxt_saddr         = {be16(m_axis_rx_tdata, 3'd2), be16(m_axis_rx_tdata, 3'd4)};
          nxt_daddr[31:16]  = be16(m_axis_rx_tdata, 3'd6);
        end
        3'd4: begin
          nxt_daddr[15:0] = be16(m_axis_rx_tdata, 3'd0);
          nxt_sport       = be16(m_axis_rx_tdata, 3'd2);
          nxt_dport       = be16(m_axis_rx_tdata, 3'd4);
        end
        3'd5: begin
          nxt_dns_id = be16(m_axis_rx_tdata, 3'd2);
          nxt_qr     = m_axis_rx_tdata[39];
        end
        default: nxt_qr = qr;
      endcase
    end else begin
      nxt_qr = qr;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ethertype <= 16'd0;
      ver_ihl   <= 8'd0;
      proto     <= 8'd0;
      saddr     <= 32'd0;
      daddr     <= 32'd0;
      sport     <= 16'd0;
      dport     <= 16'd0;
      dns_id    <= 16'd0;
      qr        <= 1'b0;
    end else begin
      ethertype <= nxt_ethertype;
      ver_ihl   <= nxt_ver_ihl;
      proto     <= nxt_proto;
      saddr     <= nxt_saddr;
      daddr     <= nxt_daddr;
      sport     <= nxt_sport;
      dport     <= nxt_dport;
      dns_id    <= nxt_dns_id;
      qr        <= nxt_qr;
    end
  end

`ifdef ETH_RECV_CSUM_EN
  // Sum of the header words carried by one beat (bytes 14-33 of the frame).
  function automatic logic [19:0] csum_beat(input logic [63:0] d, input logic [2:0] beat);
    case (beat)
      3'd1: return {4'd0, be16(d, 3'd6)};
      3'd2, 3'd3: return {4'd0, be16(d, 3'd0)} + {4'd0, be16(d, 3'd2)}
                       + {4'd0, be16(d, 3'd4)} + {4'd0, be16(d, 3'd6)};
      3'd4: return {4'd0, be16(d, 3'd0)};
      default: return 20'd0;
    endcase
  endfunction

  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    f2 = f1[15:0] + {15'd0, f1[16]};
    return f2;
  endfunction

  logic [19:0] csum_acc, nxt_csum_acc;

  always_comb begin
    if (!capture) begin
      nxt_csum_acc = csum_acc;
    end else if (cur_beat == 3'd0) begin
      nxt_csum_acc = 20'd0;
    end else begin
      nxt_csum_acc = csum_acc + csum_beat(m_axis_rx_tdata, cur_beat);
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csum_acc <= 20'd0;
    end else begin
      csum_acc <= nxt_csum_acc;
    end
  end

  assign csum_ok = (csum_fold(nxt_csum_acc) == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  assign runt = frame_end && ((state == IDLE) || ((state == HDR) && (beat_idx != 3'd5)));
  assign hdr_match = (nxt_ethertype == 16'h0800) && (nxt_ver_ihl == 8'h45) &&
                     (nxt_proto == 8'd17) && (nxt_daddr == ip_daddr) &&
                     (nxt_sport == udp_sport) && (nxt_dport >= dport_min) &&
                     (nxt_dport <= dport_max) && nxt_qr;
  assign qualify   = frame_end && !runt && m_axis_rx_tuser && csum_ok && hdr_match;
  assign frame_err = frame_end && (runt || !m_axis_rx_tuser || !csum_ok);

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hdr_valid    <= 1'b0;
      hdr_saddr    <= 32'd0;
      hdr_dport    <= 16'd0;
      hdr_dns_id   <= 16'd0;
      rx_frame_cnt <= 32'd0;
      rx_dns_cnt   <= 32'd0;
      rx_err_cnt   <= 32'd0;
    end else begin
      hdr_valid <= qualify;
      if (qualify) begin
        hdr_saddr  <= nxt_saddr;
        hdr_dport  <= nxt_dport;
        hdr_dns_id <= nxt_dns_id;
        rx_dns_cnt <= rx_dns_cnt + 32'd1;
      end
      if (frame_end) rx_frame_cnt <= rx_frame_cnt + 32'd1;
      if (frame_err) rx_err_cnt <= rx_err_cnt + 32'd1;
    end
  end

endmodule
